// File: rtl/regfile_port_ctrl.sv
// Port controller for a BitCell register array: drives the write/read word lines and D, and
// registers the two bitline buses. It also bypasses same-cycle writes, hardwires R0, and clears the array after reset.
module regfile_port_ctrl #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   SrcReg1,
  input  logic [ADDR_W-1:0]   SrcReg2,
  input  logic [ADDR_W-1:0]   DstReg,
  input  logic                WriteReg,
  input  logic [DATA_W-1:0]   DstData,
  output logic [NUM_REGS-1:0] WriteEnable,
  output logic [NUM_REGS-1:0] ReadEnable1,
  output logic [NUM_REGS-1:0] ReadEnable2,
  output logic [DATA_W-1:0]   WriteData,
  input  logic [DATA_W-1:0]   Bitline1,
  input  logic [DATA_W-1:0]   Bitline2,
  output logic [DATA_W-1:0]   SrcData1,
  output logic [DATA_W-1:0]   SrcData2,
  output logic                Busy
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   src_data1_q, src_data1_d;
  logic [DATA_W-1:0]   src_data2_q, src_data2_d;
  logic                wr_valid;
  logic                byp1, byp2;

  function automatic logic [NUM_REGS-1:0] one_hot(input logic [ADDR_W-1:0] a);
    one_hot = NUM_REGS'(1) << a;
  endfunction

  // Writes to R0 are dropped; they neither reach the array nor bypass.
  assign wr_valid = WriteReg && (DstReg != '0);
  assign byp1     = wr_valid && (DstReg == SrcReg1);
  assign byp2     = wr_valid && (DstReg == SrcReg2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      idx_q       <= ADDR_W'(1);
      src_data1_q <= '0;
      src_data2_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      src_data1_q <= src_data1_d;
      src_data2_q <= src_data2_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    src_data1_d = src_data1_q;
    src_data2_d = src_data2_q;
    WriteEnable = '0;
    ReadEnable1 = '0;
    ReadEnable2 = '0;
    WriteData   = '0;
    Busy        = 1'b1;
    if (!rst) begin
      unique case (state_q)
        ST_INIT: begin
          // Clear walk over R1..R(N-1); request inputs are ignored.
          WriteEnable = one_hot(idx_q);
          idx_d       = idx_q + ADDR_W'(1);
          src_data1_d = '0;
          src_data2_d = '0;
          if (idx_q == LAST_IDX) state_d = ST_RUN;
        end
        ST_RUN: begin
          Busy      = 1'b0;
          WriteData = DstData;
          if (wr_valid)         WriteEnable = one_hot(DstReg);
          if (SrcReg1 != '0)    ReadEnable1 = one_hot(SrcReg1);
          if (SrcReg2 != '0)    ReadEnable2 = one_hot(SrcReg2);
          if (SrcReg1 == '0)    src_data1_d = '0;
          else if (byp1)        src_data1_d = DstData;
          else                  src_data1_d = Bitline1;
          if (SrcReg2 == '0)    src_data2_d = '0;
          else if (byp2)        src_data2_d = DstData;
          else                  src_data2_d = Bitline2;
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  assign SrcData1 = src_data1_q;
  assign SrcData2 = src_data2_q;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Bench for regfile_port_ctrl: a BitCell array model drives the bitlines, and a
// register-level reference model predicts every output for directed and random traffic.
module tb_regfile_port_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  SrcReg1 = '0, SrcReg2 = '0, DstReg = '0;
  logic        WriteReg = 1'b0;
  logic [15:0] DstData = '0;
  logic [15:0] WriteEnable, ReadEnable1, ReadEnable2;
  logic [15:0] WriteData, Bitline1, Bitline2, SrcData1, SrcData2;
  logic        Busy;

  logic [15:0] noise1 = 16'h0BAD, noise2 = 16'hF00D;
  logic [15:0] cells [16];
  logic [15:0] ref_mem [16];
  bit          running = 1'b0;
  int          walk_cnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  regfile_port_ctrl dut (
    .clk(clk), .rst(rst), .SrcReg1(SrcReg1), .SrcReg2(SrcReg2), .DstReg(DstReg),
    .WriteReg(WriteReg), .DstData(DstData), .WriteEnable(WriteEnable),
    .ReadEnable1(ReadEnable1), .ReadEnable2(ReadEnable2), .WriteData(WriteData),
    .Bitline1(Bitline1), .Bitline2(Bitline2), .SrcData1(SrcData1), .SrcData2(SrcData2),
    .Busy(Busy)
  );

  always #5 clk = ~clk;

  // Array model: every selected row writes; bitlines wire-OR the selected rows, float to noise otherwise.
  always @(posedge clk) begin
    for (int i = 0; i < 16; i++) if (WriteEnable[i]) cells[i] <= WriteData;
  end

  always_comb begin
    bit any1, any2;
    Bitline1 = '0; Bitline2 = '0; any1 = 1'b0; any2 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (ReadEnable1[i]) begin Bitline1 = Bitline1 | cells[i]; any1 = 1'b1; end
      if (ReadEnable2[i]) begin Bitline2 = Bitline2 | cells[i]; any2 = 1'b1; end
    end
    if (!any1) Bitline1 = noise1;
    if (!any2) Bitline2 = noise2;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus, with outputs predicted from the register-level view.
  task automatic step(input bit r, input bit wr, input logic [3:0] dst, input logic [15:0] dd,
                      input logic [3:0] s1, input logic [3:0] s2);
    logic [15:0] e_we, e_re1, e_re2, e_wd, e_s1, e_s2;
    bit          e_busy;
    @(negedge clk);
    rst = r; WriteReg = wr; DstReg = dst; DstData = dd; SrcReg1 = s1; SrcReg2 = s2;
    noise1 = 16'($urandom); noise2 = 16'($urandom);
    e_we = '0; e_re1 = '0; e_re2 = '0; e_wd = '0; e_s1 = '0; e_s2 = '0; e_busy = 1'b1;
    if (!r && !running) begin
      e_we = 16'(1) << (walk_cnt + 1);
    end else if (!r) begin
      e_busy = 1'b0;
      e_wd   = dd;
      if (wr && dst != 0) e_we = 16'(1) << dst;
      if (s1 != 0) begin
        e_re1 = 16'(1) << s1;
        e_s1  = (wr && dst == s1) ? dd : ref_mem[s1];
      end
      if (s2 != 0) begin
        e_re2 = 16'(1) << s2;
        e_s2  = (wr && dst == s2) ? dd : ref_mem[s2];
      end
    end
    #1;
    check("write_en", WriteEnable, e_we);
    check("read_en1", ReadEnable1, e_re1);
    check("read_en2", ReadEnable2, e_re2);
    check("write_data", WriteData, e_wd);
    check("busy", 16'(Busy), 16'(e_busy));
    @(posedge clk);
    #1;
    check("src_data1", SrcData1, e_s1);
    check("src_data2", SrcData2, e_s2);
    if (r) begin
      running  = 1'b0;
      walk_cnt = 0;
    end else if (!running) begin
      ref_mem[walk_cnt + 1] = '0;
      walk_cnt++;
      if (walk_cnt == 15) running = 1'b1;
    end else if (wr && dst != 0) begin
      ref_mem[dst] = dd;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 16'h0000, 4'd0, 4'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      cells[i]   = 16'($urandom) | 16'h0001;
      ref_mem[i] = '0;
    end

    // Reset for two cycles, then the full clear walk.
    step(1'b1, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0);
    step(1'b1, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0);
    idle(15);
    check("walk_done_busy", 16'(Busy), 16'h0000);

    // Write then read back through the array.
    step(1'b0, 1'b1, 4'd5, 16'hBEEF, 4'd0, 4'd0);
    step(1'b0, 1'b0, 4'd0, 16'h0000, 4'd5, 4'd0);
    check("t2_src1", SrcData1, 16'hBEEF);

    // Same-cycle bypass on both ports.
    step(1'b0, 1'b1, 4'd3, 16'h1234, 4'd3, 4'd3);
    check("t3_src1", SrcData1, 16'h1234);
    check("t3_src2", SrcData2, 16'h1234);

    // Write to R0 is dropped and R0 reads zero.
    step(1'b0, 1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd0);
    check("t4_src2", SrcData2, 16'h0000);

    // Reset in the middle of the walk restarts it; R7 ends up cleared.
    step(1'b0, 1'b1, 4'd7, 16'hA5A5, 4'd0, 4'd0);
    step(1'b1, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0);
    idle(3);
    step(1'b1, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0);
    // Write attempt during the walk must be ignored.
    step(1'b0, 1'b1, 4'd9, 16'h5555, 4'd9, 4'd9);
    idle(14);
    step(1'b0, 1'b0, 4'd0, 16'h0, 4'd7, 4'd9);
    check("t5_r7_cleared", SrcData1, 16'h0000);
    check("t6_r9_cleared", SrcData2, 16'h0000);

    // Randomized traffic with occasional resets and a bias toward bypass hits.
    for (int n = 0; n < 800; n++) begin
      logic [3:0] d, a, b;
      d = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 3) == 0) ? d : 4'($urandom_range(0, 15));
      b = ($urandom_range(0, 3) == 0) ? d : (($urandom_range(0, 4) == 0) ? a : 4'($urandom_range(0, 15)));
      step(($urandom_range(0, 79) == 0), 1'($urandom), d, 16'($urandom), a, b);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
